serial_add_sequencer: RTL and testbench

- Adds two WIDTH-bit operands two bits per clock by driving one instance of the team's 2-bit ripple adder (rippleADD: a[1:0], b[1:0], carryIn -> sum[1:0], carryOut).
- Sits directly upstream of that adder: latches operands, feeds 2-bit slices LSB-first, registers the slice carry back into the next slice, and assembles the wide result.
- Lets the small combinational adder serve wider datapaths in later labs.

---
 rtl/serial_add_sequencer.sv | 122 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Two-bit-per-cycle serial adder: drives a 2-bit ripple adder with LSB-first operand slices
// and assembles {carryOut,sum} = a + b + carryIn over WIDTH/2 RUN cycles.

module rippleADD (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       carryIn,
  output logic [1:0] sum,
  output logic       carryOut
);
  logic c1;
  always_comb begin
    sum[0]   = a[0] ^ b[0] ^ carryIn;
    c1       = (a[0] & b[0]) | (carryIn & (a[0] ^ b[0]));
    sum[1]   = a[1] ^ b[1] ^ c1;
    carryOut = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  end
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       add_sum;
  logic             add_co;
  logic [WIDTH+1:0] acc_cat;

  rippleADD u_add (
    .a        (a_q[1:0]),
    .b        (b_q[1:0]),
    .carryIn  (c_q),
    .sum      (add_sum),
    .carryOut (add_co)
  );

  // New slice enters at the MSB end; after N shifts the slices sit in order.
  assign acc_cat = {add_sum, acc_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_RUN: begin
        acc_d = acc_cat[WIDTH+1:2];
        c_d   = add_co;
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = acc_d;
          cout_d  = add_co;
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = carryIn;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign carryOut = cout_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: WIDTH=8 directed/random scenarios and a WIDTH=2 exhaustive sweep.

module tb_serial_add_sequencer;
  logic       clk = 1'b0;
  logic       rst8, start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       rst2, start2, ci2, busy2, done2, co2;
  logic [1:0] a2, b2, sum2;

  int vec  = 0;
  int errs = 0;
  int done8_cnt = 0;
  int done2_cnt = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .carryIn(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .carryOut(co8)
  );

  serial_add_sequencer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .carryIn(ci2),
    .busy(busy2), .done(done2), .sum(sum2), .carryOut(co2)
  );

  always @(negedge clk) begin
    if (done8 === 1'b1) done8_cnt <= done8_cnt + 1;
    if (done2 === 1'b1) done2_cnt <= done2_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 request and wait (bounded) for its done pulse.
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output int lat, output int bcnt);
    a8 = ia; b8 = ib; ci8 = ic; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
    bcnt = (busy8 === 1'b1) ? 1 : 0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      tick;
      lat++;
      if (busy8 === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst8 = 1'b1; rst2 = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
    tick; tick;
    rst8 = 1'b0; rst2 = 1'b0;
    vec++;
    if ({busy8, done8, co8, sum8} !== 11'd0) begin
      errs++; $display("FAIL reset8: got busy=%b done=%b co=%b sum=%h, want all 0", busy8, done8, co8, sum8);
    end
    vec++;
    if ({busy2, done2, co2, sum2} !== 5'd0) begin
      errs++; $display("FAIL reset2: got busy=%b done=%b co=%b sum=%h, want all 0", busy2, done2, co2, sum2);
    end
  endtask

  task automatic test_basic;
    int lat, bcnt;
    do_op8(8'h5A, 8'h3C, 1'b0, lat, bcnt);
    vec++;
    if (lat != 4) begin errs++; $display("FAIL basic_latency: got %0d edges, want 4", lat); end
    vec++;
    if (bcnt != 4) begin errs++; $display("FAIL basic_busy: got %0d cycles, want 4", bcnt); end
    vec++;
    if ({co8, sum8} !== 9'h096) begin errs++; $display("FAIL basic_result: got %h, want 096", {co8, sum8}); end
    tick;
    vec++;
    if (done8 !== 1'b0 || {co8, sum8} !== 9'h096) begin
      errs++; $display("FAIL basic_hold: got done=%b result=%h, want done=0 result=096", done8, {co8, sum8});
    end
  endtask

  task automatic test_carry;
    int lat, bcnt;
    do_op8(8'hFF, 8'h01, 1'b0, lat, bcnt);
    vec++;
    if ({co8, sum8} !== 9'h100) begin errs++; $display("FAIL carry_ripple: got %h, want 100", {co8, sum8}); end
    do_op8(8'hFF, 8'hFF, 1'b1, lat, bcnt);
    vec++;
    if ({co8, sum8} !== 9'h1FF) begin errs++; $display("FAIL carry_max: got %h, want 1ff", {co8, sum8}); end
  endtask

  task automatic test_ignore_start;
    int base, lat;
    tick;
    base = done8_cnt;
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick; tick;
    vec++;
    if (busy8 !== 1'b1) begin errs++; $display("FAIL ignore_busy: got %b, want 1", busy8); end
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick;
    start8 = 1'b0; a8 = 8'h77; b8 = 8'h99;
    lat = 3;
    while (done8 !== 1'b1 && lat < 20) begin tick; lat++; end
    vec++;
    if (lat != 4 || {co8, sum8} !== 9'h030) begin
      errs++; $display("FAIL ignore_result: got lat=%0d result=%h, want lat=4 result=030", lat, {co8, sum8});
    end
    repeat (8) tick;
    vec++;
    if (done8_cnt - base != 1) begin errs++; $display("FAIL ignore_pulses: got %0d, want 1", done8_cnt - base); end
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; start8 = 1'b1;
    tick;
    a8 = 8'h03; b8 = 8'h04;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin tick; lat++; end
    vec++;
    if (lat != 4 || {co8, sum8} !== 9'h003) begin
      errs++; $display("FAIL b2b_first: got lat=%0d result=%h, want lat=4 result=003", lat, {co8, sum8});
    end
    tick;
    gap = 1;
    while (done8 !== 1'b1 && gap < 20) begin tick; gap++; end
    start8 = 1'b0;
    vec++;
    if (gap != 5 || {co8, sum8} !== 9'h007) begin
      errs++; $display("FAIL b2b_second: got gap=%0d result=%h, want gap=5 result=007", gap, {co8, sum8});
    end
    tick;
    vec++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errs++; $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_reset_mid_run;
    int base, lat, bcnt;
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    tick;
    base = done8_cnt;
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0;
    vec++;
    if ({busy8, done8, co8, sum8} !== 11'd0) begin
      errs++; $display("FAIL midrst_clear: got busy=%b done=%b co=%b sum=%h, want all 0", busy8, done8, co8, sum8);
    end
    repeat (8) tick;
    vec++;
    if (done8_cnt != base) begin errs++; $display("FAIL midrst_nodone: got %0d pulses, want 0", done8_cnt - base); end
    do_op8(8'hAA, 8'h55, 1'b1, lat, bcnt);
    vec++;
    if (lat != 4 || {co8, sum8} !== 9'h100) begin
      errs++; $display("FAIL midrst_restart: got lat=%0d result=%h, want lat=4 result=100", lat, {co8, sum8});
    end
  endtask

  task automatic test_start_rst_same_edge;
    rst8 = 1'b1; start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    tick;
    rst8 = 1'b0; start8 = 1'b0;
    tick;
    vec++;
    if (busy8 !== 1'b0 || {co8, sum8} !== 9'h000) begin
      errs++; $display("FAIL rst_vs_start: got busy=%b result=%h, want busy=0 result=000", busy8, {co8, sum8});
    end
  endtask

  task automatic test_random;
    int lat, bcnt;
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_r = 9'(ra) + 9'(rb) + 9'(rc);
      do_op8(ra, rb, rc, lat, bcnt);
      vec++;
      if (lat != 4 || {co8, sum8} !== exp_r) begin
        errs++; $display("FAIL random[%0d] %h+%h+%b: got lat=%0d result=%h, want lat=4 result=%h",
                         i, ra, rb, rc, lat, {co8, sum8}, exp_r);
      end
      if ($urandom_range(0, 1) == 1) tick;
    end
  endtask

  task automatic test_width2_exhaustive;
    int base;
    logic [2:0] exp_r;
    tick;
    base = done2_cnt;
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i >> 3); b2 = 2'(i >> 1); ci2 = 1'(i);
      exp_r = 3'(a2) + 3'(b2) + 3'(ci2);
      start2 = 1'b1;
      tick;
      a2 = 2'($urandom); b2 = 2'($urandom);
      tick;
      vec++;
      if (done2 !== 1'b1 || {co2, sum2} !== exp_r) begin
        errs++; $display("FAIL w2[%0d]: got done=%b result=%h, want done=1 result=%h", i, done2, {co2, sum2}, exp_r);
      end
    end
    start2 = 1'b0;
    tick; tick;
    vec++;
    if (done2_cnt - base != 32) begin errs++; $display("FAIL w2_pulses: got %0d, want 32", done2_cnt - base); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_start_rst_same_edge;
    test_random;
    test_width2_exhaustive;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
